// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch requester (if_*)
// and a data requester (d_*). One transaction is outstanding at a time. Data normally wins,
// but a waiting fetch is forced through after STARVE_MAX data grants made while it waited.
//
// Ports:
//   clk, reset                         single clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_rvalid            fetch request and response
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_rvalid   data request and response
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata     shared memory port (MEM_LAT read latency)
//   stall_if, stall_mem                pipeline holds while a request is not yet answered
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;

    localparam logic [2:0] LatInit   = 3'(MEM_LAT);
    localparam logic [2:0] StarveTop = 3'(STARVE_MAX);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  starve_q, starve_d;
    logic        lat_we_q, lat_we_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic grant_if, grant_d, issue, busy, done, if_done, d_done;

    always_comb begin
        busy     = (state_q == BUSY_IF) || (state_q == BUSY_D);
        grant_if = ~reset && (state_q == IDLE) && if_req && (~d_req || (starve_q == StarveTop));
        grant_d  = ~reset && (state_q == IDLE) && d_req && ~grant_if;
        issue    = grant_if || grant_d;
        // Counter holds MEM_LAT in cycle T+1, so it reads 1 in the completion cycle T+MEM_LAT.
        done     = ~reset && busy && (cnt_q == 3'd1);
        if_done  = done && (state_q == BUSY_IF);
        d_done   = done && (state_q == BUSY_D);
    end

    // Memory port drive: live requester values on the issue cycle, latched values while busy.
    always_comb begin
        mem_en    = issue;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (grant_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_if) begin
            mem_addr  = if_addr;
        end else if (busy) begin
            mem_we    = lat_we_q;
            mem_addr  = lat_addr_q;
            mem_wdata = lat_wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        if (issue) begin
            state_d     = grant_if ? BUSY_IF : BUSY_D;
            cnt_d       = LatInit;
            lat_we_d    = mem_we;
            lat_addr_d  = mem_addr;
            lat_wdata_d = mem_wdata;
            if (grant_if) begin
                starve_d = 3'd0;
            end else if (if_req && (starve_q < StarveTop)) begin
                starve_d = starve_q + 3'd1;
            end
        end else if (done) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else if (busy) begin
            cnt_d = cnt_q - 3'd1;
        end else begin
            // Covers IDLE with no request and the unused encoding.
            state_d = IDLE;
        end
    end

    // Response data: pass mem_rdata through on completion, then hold it in the register.
    always_comb begin
        if_rdata_d = if_done ? mem_rdata : if_rdata_q;
        d_rdata_d  = d_done ? (lat_we_q ? 32'd0 : mem_rdata) : d_rdata_q;
        if_rdata   = if_rdata_d;
        d_rdata    = d_rdata_d;
        if_rvalid  = if_done;
        d_rvalid   = d_done;
        stall_if   = if_req & ~if_rvalid;
        stall_mem  = d_req & ~d_rvalid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            starve_q    <= 3'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_rvalid, d_rvalid, mem_en, mem_we, stall_if, stall_mem;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Each cycle: change inputs just after the falling edge, sample outputs 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;

        // Reset: no issue while reset is high, even with a request present.
        next_cycle();
        next_cycle(); if_req = 1'b1; if_addr = 32'h10; #1;
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        next_cycle(); reset = 1'b0; if_req = 1'b0; #1;
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_d_rdata", d_rdata, 32'd0);
        check_eq("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);

        // Fetch only: issue at 0, complete at 2, next issue at 3.
        next_cycle(); if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h1111_2222; #1;
        check_eq("f_issue_en", 32'(mem_en), 32'd1);
        check_eq("f_issue_addr", mem_addr, 32'h10);
        check_eq("f_issue_we", 32'(mem_we), 32'd0);
        check_eq("f_stall_if0", 32'(stall_if), 32'd1);
        next_cycle(); #1;
        check_eq("f_busy_en", 32'(mem_en), 32'd0);
        check_eq("f_busy_addr", mem_addr, 32'h10);
        check_eq("f_busy_rvalid", 32'(if_rvalid), 32'd0);
        next_cycle(); #1;
        check_eq("f_done_rvalid", 32'(if_rvalid), 32'd1);
        check_eq("f_done_rdata", if_rdata, 32'h1111_2222);
        check_eq("f_done_stall", 32'(stall_if), 32'd0);
        next_cycle(); if_addr = 32'h14; mem_rdata = 32'h3333_4444; #1;
        check_eq("f_next_en", 32'(mem_en), 32'd1);
        check_eq("f_next_addr", mem_addr, 32'h14);
        next_cycle(); if_req = 1'b0; mem_rdata = 32'h0; #1;
        check_eq("f_hold_rdata", if_rdata, 32'h1111_2222);
        next_cycle(); mem_rdata = 32'h3333_4444; #1;
        check_eq("f_noabort_rvalid", 32'(if_rvalid), 32'd1);
        check_eq("f_noabort_rdata", if_rdata, 32'h3333_4444);
        next_cycle(); #1;
        check_eq("f_idle_en", 32'(mem_en), 32'd0);
        check_eq("f_idle_addr", mem_addr, 32'd0);

        // Simultaneous requests: data first, fetch at 3, fetch stalled 0..4.
        next_cycle();
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        mem_rdata = 32'h5555_6666; #1;
        check_eq("s_issue_addr", mem_addr, 32'h200);
        check_eq("s_stalls0", {30'd0, stall_if, stall_mem}, 32'd3);
        next_cycle(); #1;
        check_eq("s_stall_if1", 32'(stall_if), 32'd1);
        next_cycle(); #1;
        check_eq("s_d_rvalid", 32'(d_rvalid), 32'd1);
        check_eq("s_d_rdata", d_rdata, 32'h5555_6666);
        check_eq("s_stalls2", {30'd0, stall_if, stall_mem}, 32'd2);
        next_cycle(); d_req = 1'b0; #1;
        check_eq("s_f_issue", {31'd0, mem_en}, 32'd1);
        check_eq("s_f_addr", mem_addr, 32'h20);
        check_eq("s_stall_if3", 32'(stall_if), 32'd1);
        next_cycle(); #1;
        check_eq("s_stall_if4", 32'(stall_if), 32'd1);
        next_cycle(); #1;
        check_eq("s_if_rvalid", 32'(if_rvalid), 32'd1);
        check_eq("s_stall_if5", 32'(stall_if), 32'd0);
        next_cycle(); if_req = 1'b0; #1;

        // Store: write data on the port, d_rvalid at T+2 with zero read data.
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h7777_8888; #1;
        check_eq("w_issue_we", 32'(mem_we), 32'd1);
        check_eq("w_issue_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("w_issue_addr", mem_addr, 32'h40);
        next_cycle(); #1;
        check_eq("w_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("w_hold_we", 32'(mem_we), 32'd1);
        next_cycle(); #1;
        check_eq("w_rvalid", 32'(d_rvalid), 32'd1);
        check_eq("w_rdata", d_rdata, 32'd0);
        next_cycle(); d_req = 1'b0; d_we = 1'b0; #1;
        check_eq("w_idle_we", 32'(mem_we), 32'd0);
        check_eq("w_hold_rdata", d_rdata, 32'd0);

        // Starvation: issues every 3 cycles; 4 data, then fetch at 12, then data again.
        for (int k = 0; k < 21; k++) begin
            next_cycle();
            if (k == 0) begin
                d_req = 1'b1; if_req = 1'b1; d_addr = 32'h300; if_addr = 32'h80;
                mem_rdata = 32'hABCD_0000;
            end
            #1;
            check_eq($sformatf("sv_en_%0d", k), 32'(mem_en), (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k % 3 == 0)
                check_eq($sformatf("sv_addr_%0d", k), mem_addr, (k == 12) ? 32'h80 : 32'h300);
            check_eq($sformatf("sv_d_rvalid_%0d", k), 32'(d_rvalid),
                     ((k % 3 == 2) && (k != 14)) ? 32'd1 : 32'd0);
            check_eq($sformatf("sv_if_rvalid_%0d", k), 32'(if_rvalid),
                     (k == 14) ? 32'd1 : 32'd0);
        end
        next_cycle(); d_req = 1'b0; if_req = 1'b0; #1;
        check_eq("sv_d_rdata_held", d_rdata, 32'hABCD_0000);

        // Reset at T+1 of a fetch: response discarded, fresh request issued right after.
        next_cycle(); if_req = 1'b1; if_addr = 32'h90; mem_rdata = 32'hCAFE_0094; #1;
        check_eq("r_issue_addr", mem_addr, 32'h90);
        next_cycle(); reset = 1'b1; #1;
        check_eq("r_in_reset_en", 32'(mem_en), 32'd0);
        next_cycle(); reset = 1'b0; if_addr = 32'h94; #1;
        check_eq("r_no_rvalid", 32'(if_rvalid), 32'd0);
        check_eq("r_if_rdata", if_rdata, 32'd0);
        check_eq("r_d_rdata", d_rdata, 32'd0);
        check_eq("r_reissue_en", 32'(mem_en), 32'd1);
        check_eq("r_reissue_addr", mem_addr, 32'h94);
        next_cycle(); #1;
        next_cycle(); #1;
        check_eq("r_done_rvalid", 32'(if_rvalid), 32'd1);
        check_eq("r_done_rdata", if_rdata, 32'hCAFE_0094);
        next_cycle(); if_req = 1'b0; #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
